ysyx_24090003_wbu: RTL and testbench
====================================

YSYX_24090003_WBU -- requirements
Module: ysyx_24090003_wbu

Interface
REQ-001 SHALL have parameter NREG, default 32, meaning number of architectural registers; x0 is hardwired zero.
REQ-002 SHALL have port cpu_clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port cpu_rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have issue port: issue_valid in 1, issue_wen in 1, issue_rd in 5, issue_rs1 in 5, issue_rs2 in 5, issue_ready out 1.
REQ-005 SHALL have ALU result port: alu_valid in 1, alu_ready out 1, alu_rd in 5, alu_data in 32.
REQ-006 SHALL have LSU result port: lsu_valid in 1, lsu_ready out 1, lsu_rd in 5, lsu_data in 32.
REQ-007 SHALL have register-file write port: wb_wen out 1, wb_rd out 5, wb_data out 32; it drives the register file write enable, destination index and write data.
REQ-008 SHALL have status outputs: busy_vec out 32 (scoreboard), wb_err out 1 (sticky protocol error).

Function
REQ-009 SHALL keep scoreboard busy[31:0]; busy[0] SHALL always read 0.
REQ-010 SHALL compute hazard = busy[issue_rs1] | busy[issue_rs2] | (issue_wen & busy[issue_rd]); this covers RAW and WAW.
REQ-011 SHALL drive issue_ready = ~hazard combinationally; an issue is accepted when issue_valid & issue_ready.
REQ-012 SHALL set busy[issue_rd] at the edge ending an accepted issue with issue_wen=1 and issue_rd!=0.
REQ-013 SHALL arbitrate results with fixed priority: LSU first. lsu_ready SHALL be 1 always. alu_ready SHALL be ~lsu_valid.
REQ-014 SHALL load the output stage at the edge ending an accepted result: wb_rd<=rd and wb_data<=data. wb_wen<=(rd!=0). With no accepted result, wb_wen<=0.
REQ-015 SHALL have 1-cycle latency from result acceptance to wb_wen high; wb_wen SHALL be high for exactly one cycle per result.
REQ-016 SHALL clear busy[wb_rd] at the edge where wb_wen=1, so the register file write and the busy clear commit on the same edge.
REQ-017 SHALL apply set over clear when one edge both sets and clears the same index.
REQ-018 SHALL suppress the write for a result with rd=0: no wb_wen, no scoreboard change.
REQ-019 SHALL set wb_err at the edge of an accepted result with rd!=0 whose busy bit is 0; wb_err SHALL stay set until reset. The write still proceeds.
REQ-020 SHALL hold wb_rd and wb_data stable while wb_wen=0.
REQ-021 SHALL expose busy_vec as the registered scoreboard, not the next-state value.

Reset
REQ-022 SHALL, on cpu_rst=1 at an edge, clear busy to 0, wb_wen to 0, wb_rd to 0, wb_data to 0 and wb_err to 0.
REQ-023 SHALL discard any issue or result presented in a reset cycle; an output stage write in flight SHALL be dropped.
REQ-024 SHALL still compute issue_ready, alu_ready and lsu_ready combinationally during reset, from the scoreboard state.

Structure
REQ-025 SHALL place the register-index width (5), data width (32) and the x0 index in a shared package ysyx_24090003_pkg.
REQ-026 SHALL implement the scoreboard as sub-module ysyx_24090003_scoreboard, with set port, clear port and two read ports plus a WAW port.
REQ-027 SHALL implement the arbiter and output stage in the top module; no other sub-modules.

Verification
REQ-028 RAW stall: issue rd=5 accepted, then issue rs1=5 -> issue_ready=0 until the edge where wb_wen=1 with wb_rd=5; issue_ready=1 in the next cycle.
REQ-029 Arbitration: alu_valid and lsu_valid both high in the same cycle (rd 3 and 4) -> alu_ready=0, LSU written first; the ALU result follows one cycle later with wb_rd=3.
REQ-030 x0: issue rd=0, then result rd=0 with data 0xDEADBEEF -> busy_vec stays 0, wb_wen never asserts, wb_err=0.
REQ-031 Set over clear: wb_wen=1 with wb_rd=7 on the same edge as an accepted issue with rd=7 -> busy[7]=1 after that edge.
REQ-032 Error and reset: result rd=9 with busy[9]=0 -> wb_err=1 and a write occurs with wb_rd=9. Then cpu_rst pulsed while wb_wen=1 -> all outputs 0 after the reset edge.

Source files
------------

// File: rtl/ysyx_24090003_pkg.sv
// Shared widths, the x0 index, the write-back record and a one-hot helper
// for the write-back unit and its scoreboard.
package ysyx_24090003_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;
  localparam logic [REG_W-1:0] X0_IDX = 5'd0;

  // One accepted result heading for the register file.
  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } wb_res_t;

  // One-hot mask selecting a single register index.
  function automatic logic [31:0] reg_onehot(input logic [REG_W-1:0] idx);
    return 32'd1 << idx;
  endfunction

endpackage

// File: rtl/ysyx_24090003_scoreboard.sv
// Register busy scoreboard: one set port (issue), one clear port
// (write-back), two operand read ports and a destination (WAW) read port.
// Bit 0 never becomes busy; indices at or above NREG are never busy.
module ysyx_24090003_scoreboard
  import ysyx_24090003_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic             cpu_clk,
  input  logic             cpu_rst,
  input  logic             set_en,
  input  logic [REG_W-1:0] set_idx,
  input  logic             clr_en,
  input  logic [REG_W-1:0] clr_idx,
  input  logic [REG_W-1:0] rs1_idx,
  output logic             rs1_busy,
  input  logic [REG_W-1:0] rs2_idx,
  output logic             rs2_busy,
  input  logic [REG_W-1:0] waw_idx,
  output logic             waw_busy,
  output logic [31:0]      busy_vec
);

  // Bits that may ever be busy: implemented registers other than x0.
  localparam logic [31:0] VALID_MASK = (NREG >= 32) ? 32'hFFFF_FFFE :
                                       (((32'd1 << NREG) - 32'd1) & 32'hFFFF_FFFE);

  logic [31:0] busy_r;
  logic [31:0] set_mask_s;
  logic [31:0] clr_mask_s;
  logic [31:0] busy_nxt_s;

  // Next scoreboard: clear applied first, then set, so a set wins a tie.
  always_comb begin
    set_mask_s = set_en ? reg_onehot(set_idx) : 32'd0;
    clr_mask_s = clr_en ? reg_onehot(clr_idx) : 32'd0;
    busy_nxt_s = ((busy_r & ~clr_mask_s) | set_mask_s) & VALID_MASK;
  end

  // Scoreboard register with synchronous reset.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      busy_r <= 32'd0;
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  assign rs1_busy = busy_r[rs1_idx];
  assign rs2_busy = busy_r[rs2_idx];
  assign waw_busy = busy_r[waw_idx];
  assign busy_vec = busy_r;

endmodule

// File: rtl/ysyx_24090003_wbu.sv
// Write-back unit: hazard-gated issue, fixed-priority (LSU first) result
// arbitration and a one-cycle registered register-file write stage.
module ysyx_24090003_wbu
  import ysyx_24090003_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  input  logic              issue_valid,
  input  logic              issue_wen,
  input  logic [REG_W-1:0]  issue_rd,
  input  logic [REG_W-1:0]  issue_rs1,
  input  logic [REG_W-1:0]  issue_rs2,
  output logic              issue_ready,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [REG_W-1:0]  alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [REG_W-1:0]  lsu_rd,
  input  logic [DATA_W-1:0] lsu_data,
  output logic              wb_wen,
  output logic [REG_W-1:0]  wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic [31:0]       busy_vec,
  output logic              wb_err
);

  logic    rs1_busy_s;
  logic    rs2_busy_s;
  logic    waw_busy_s;
  logic    hazard_s;
  logic    issue_set_s;
  logic    res_valid_s;
  wb_res_t res_s;
  logic    res_write_s;
  logic    res_orphan_s;

  ysyx_24090003_scoreboard #(
    .NREG (NREG)
  ) u_scoreboard (
    .cpu_clk  (cpu_clk),
    .cpu_rst  (cpu_rst),
    .set_en   (issue_set_s),
    .set_idx  (issue_rd),
    .clr_en   (wb_wen),
    .clr_idx  (wb_rd),
    .rs1_idx  (issue_rs1),
    .rs1_busy (rs1_busy_s),
    .rs2_idx  (issue_rs2),
    .rs2_busy (rs2_busy_s),
    .waw_idx  (issue_rd),
    .waw_busy (waw_busy_s),
    .busy_vec (busy_vec)
  );

  // RAW on either source, WAW on the destination when it will be written.
  assign hazard_s    = rs1_busy_s | rs2_busy_s | (issue_wen & waw_busy_s);
  assign issue_ready = ~hazard_s;
  assign issue_set_s = issue_valid & issue_ready & issue_wen & (issue_rd != X0_IDX);

  assign lsu_ready = 1'b1;
  assign alu_ready = ~lsu_valid;

  // Result arbiter: the LSU always wins; the ALU waits while it is valid.
  always_comb begin
    res_valid_s = 1'b0;
    res_s.rd    = 5'd0;
    res_s.data  = 32'd0;
    if (lsu_valid) begin
      res_valid_s = 1'b1;
      res_s.rd    = lsu_rd;
      res_s.data  = lsu_data;
    end else if (alu_valid) begin
      res_valid_s = 1'b1;
      res_s.rd    = alu_rd;
      res_s.data  = alu_data;
    end else begin
      res_valid_s = 1'b0;
    end
  end

  // x0 results are swallowed; a result for a non-busy register is flagged.
  assign res_write_s  = res_valid_s & (res_s.rd != X0_IDX);
  assign res_orphan_s = res_write_s & ~busy_vec[res_s.rd];

  // Output stage: one-cycle write pulse; index/data held between writes.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      wb_wen  <= 1'b0;
      wb_rd   <= 5'd0;
      wb_data <= 32'd0;
      wb_err  <= 1'b0;
    end else begin
      wb_wen <= res_write_s;
      if (res_write_s) begin
        wb_rd   <= res_s.rd;
        wb_data <= res_s.data;
      end
      if (res_orphan_s) begin
        wb_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_24090003_wbu.sv
// Self-checking bench for ysyx_24090003_wbu: directed scenarios followed by
// random traffic, all checked against a cycle-level reference model.
module tb_ysyx_24090003_wbu;

  logic        cpu_clk;
  logic        cpu_rst;
  logic        issue_valid, issue_wen;
  logic [4:0]  issue_rd, issue_rs1, issue_rs2;
  logic        issue_ready;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid, lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        wb_wen;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] busy_vec;
  logic        wb_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: registers pending write-back, the output stage, error flag.
  bit [31:0] m_busy;
  bit        m_wen;
  bit [4:0]  m_rd;
  bit [31:0] m_data;
  bit        m_err;

  ysyx_24090003_wbu #(.NREG(32)) dut (
    .cpu_clk     (cpu_clk),
    .cpu_rst     (cpu_rst),
    .issue_valid (issue_valid),
    .issue_wen   (issue_wen),
    .issue_rd    (issue_rd),
    .issue_rs1   (issue_rs1),
    .issue_rs2   (issue_rs2),
    .issue_ready (issue_ready),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .lsu_valid   (lsu_valid),
    .lsu_ready   (lsu_ready),
    .lsu_rd      (lsu_rd),
    .lsu_data    (lsu_data),
    .wb_wen      (wb_wen),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .busy_vec    (busy_vec),
    .wb_err      (wb_err)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive at the falling edge, check ready signals, step
  // the model across the rising edge and check the registered outputs.
  task automatic step(input bit rst,
                      input bit iv, input bit iw, input bit [4:0] ird,
                      input bit [4:0] irs1, input bit [4:0] irs2,
                      input bit av, input bit [4:0] ard, input bit [31:0] adat,
                      input bit lv, input bit [4:0] lrd, input bit [31:0] ldat);
    bit        exp_rdy;
    bit [31:0] nb;
    bit        res_v;
    bit [4:0]  res_rd;
    bit [31:0] res_dat;
    cpu_rst = rst;
    issue_valid = iv; issue_wen = iw; issue_rd = ird; issue_rs1 = irs1; issue_rs2 = irs2;
    alu_valid = av; alu_rd = ard; alu_data = adat;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ldat;
    #1;
    exp_rdy = !(m_busy[irs1] || m_busy[irs2] || (iw && m_busy[ird]));
    check_eq("issue_ready", {31'd0, issue_ready}, {31'd0, exp_rdy});
    check_eq("alu_ready", {31'd0, alu_ready}, {31'd0, !lv});
    check_eq("lsu_ready", {31'd0, lsu_ready}, 32'd1);

    res_v   = lv || av;
    res_rd  = lv ? lrd : ard;
    res_dat = lv ? ldat : adat;
    nb = m_busy;
    if (m_wen) nb[m_rd] = 1'b0;
    if (iv && exp_rdy && iw && ird != 5'd0) nb[ird] = 1'b1;

    @(posedge cpu_clk);
    #1;
    if (rst) begin
      m_busy = 32'd0; m_wen = 1'b0; m_rd = 5'd0; m_data = 32'd0; m_err = 1'b0;
    end else begin
      if (res_v && res_rd != 5'd0 && !m_busy[res_rd]) m_err = 1'b1;
      m_busy = nb;
      m_wen  = res_v && res_rd != 5'd0;
      if (m_wen) begin
        m_rd   = res_rd;
        m_data = res_dat;
      end
    end
    check_eq("wb_wen", {31'd0, wb_wen}, {31'd0, m_wen});
    check_eq("wb_rd", {27'd0, wb_rd}, {27'd0, m_rd});
    check_eq("wb_data", wb_data, m_data);
    check_eq("busy_vec", busy_vec, m_busy);
    check_eq("wb_err", {31'd0, wb_err}, {31'd0, m_err});
    @(negedge cpu_clk);
  endtask

  task automatic idle(input bit rst);
    step(rst, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    m_busy = 32'd0; m_wen = 1'b0; m_rd = 5'd0; m_data = 32'd0; m_err = 1'b0;
    cpu_rst = 1'b1;
    issue_valid = 1'b0; issue_wen = 1'b0; issue_rd = 5'd0; issue_rs1 = 5'd0; issue_rs2 = 5'd0;
    alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
    lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_data = 32'd0;
    @(negedge cpu_clk);
    idle(1'b1);
    idle(1'b1);

    // RAW stall on x5 until its write-back edge.
    step(0, 1, 1, 5'd5, 5'd0, 5'd0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    step(0, 1, 0, 5'd0, 5'd5, 5'd0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    step(0, 1, 0, 5'd0, 5'd5, 5'd0, 0, 5'd0, 32'd0, 1, 5'd5, 32'h5555_0005);
    step(0, 1, 0, 5'd0, 5'd5, 5'd0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    step(0, 1, 0, 5'd0, 5'd5, 5'd0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);

    // Simultaneous ALU (x3) and LSU (x4) results: LSU first, ALU next cycle.
    step(0, 1, 1, 5'd3, 5'd0, 5'd0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    step(0, 1, 1, 5'd4, 5'd0, 5'd0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    step(0, 0, 0, 5'd0, 5'd0, 5'd0, 1, 5'd3, 32'hA1A1_0003, 1, 5'd4, 32'hB2B2_0004);
    step(0, 0, 0, 5'd0, 5'd0, 5'd0, 1, 5'd3, 32'hA1A1_0003, 0, 5'd0, 32'd0);
    idle(1'b0);

    // x0: never busy, never written, no error.
    step(0, 1, 1, 5'd0, 5'd0, 5'd0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    step(0, 0, 0, 5'd0, 5'd0, 5'd0, 1, 5'd0, 32'hDEAD_BEEF, 0, 5'd0, 32'd0);
    idle(1'b0);

    // Set over clear on x7: orphan write of x7 retires as x7 is re-issued.
    step(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 5'd0, 32'd0, 1, 5'd7, 32'h7777_0007);
    step(0, 1, 1, 5'd7, 5'd0, 5'd0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    idle(1'b0);
    idle(1'b1);

    // Orphan result on x9 sets the error, then reset kills the in-flight write.
    step(0, 0, 0, 5'd0, 5'd0, 5'd0, 1, 5'd9, 32'h9999_0009, 0, 5'd0, 32'd0);
    idle(1'b1);
    idle(1'b0);

    // Random traffic over a small register window to force hazards.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 3) == 0, 5'($urandom_range(0, 7)), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
